// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control block: operation codes, ALUOp classes,
// R-type function fields and the multiply FSM state encoding.
package alu_ctrl_pkg;

  // ALU operation codes driven to the datapath
  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_NOR     = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_MOV     = 4'b0100;
  localparam logic [3:0] OP_SQU     = 4'b0101;
  localparam logic [3:0] OP_MULT    = 4'b0110;
  localparam logic [3:0] OP_INVALID = 4'b1001;

  // ALUOp classes from the main control unit
  localparam logic [2:0] ALUOP_MOV   = 3'b001;
  localparam logic [2:0] ALUOP_SQU   = 3'b010;
  localparam logic [2:0] ALUOP_ADDI  = 3'b100;
  localparam logic [2:0] ALUOP_ORI   = 3'b101;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  // R-type function fields
  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_MULT = 6'b100101;
  localparam logic [5:0] FUNC_NOR  = 6'b100111;

  // Multiply sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALUOp/function decode into the 4-bit ALU operation code,
// plus the flag marking operations that need the iterative multiplier.
module alu_op_decoder
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] i_alu_op,
  input  logic [5:0] i_func,
  output logic [3:0] o_alu_operation,
  output logic       o_multicycle
);

  // Wildcard decode; class-only ops ignore the function field
  always_comb begin
    o_alu_operation = OP_INVALID;
    casez ({i_alu_op, i_func})
      {ALUOP_RTYPE, FUNC_AND}:  o_alu_operation = OP_AND;
      {ALUOP_RTYPE, FUNC_NOR}:  o_alu_operation = OP_NOR;
      {ALUOP_RTYPE, FUNC_ADD}:  o_alu_operation = OP_ADD;
      {ALUOP_RTYPE, FUNC_MULT}: o_alu_operation = OP_MULT;
      {ALUOP_ADDI,  6'b??????}: o_alu_operation = OP_ADD;
      {ALUOP_ORI,   6'b??????}: o_alu_operation = OP_OR;
      {ALUOP_MOV,   6'b??????}: o_alu_operation = OP_MOV;
      {ALUOP_SQU,   6'b??????}: o_alu_operation = OP_SQU;
      default:                  o_alu_operation = OP_INVALID;
    endcase
  end

  assign o_multicycle = (o_alu_operation == OP_SQU) || (o_alu_operation == OP_MULT);

endmodule

// File: rtl/alu_multicycle_ctrl.sv
// ALU control with iterative shift-add multiplier for MULT and SQU.
// Retires STEP_BITS multiplier bits per cycle; DATA_WIDTH/STEP_BITS RUN cycles.
// Optional: define ALU_SIGNED_MUL_EN for two's-complement operands
// (magnitudes are multiplied, result negated on the output load path).
module alu_multicycle_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STEP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            ALUOp,
  input  logic [5:0]            ALUFunction,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [3:0]            alu_operation_o,
  output logic                  multicycle_o,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] product_hi_o,
  output logic [DATA_WIDTH-1:0] product_lo_o
);

  localparam int N     = DATA_WIDTH / STEP_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PW    = 2 * DATA_WIDTH;

  logic [3:0]            w_alu_op;
  logic                  w_multicycle;
  logic                  w_accept;
  logic                  w_is_squ;
  logic [DATA_WIDTH-1:0] w_mag_a;
  logic [DATA_WIDTH-1:0] w_mag_b;
  logic [PW-1:0]         w_partial;
  logic [PW-1:0]         w_acc_nxt;
  logic [PW-1:0]         w_result;

  state_t                r_state;
  logic [PW-1:0]         r_a;     // multiplicand, shifts left into the upper half
  logic [DATA_WIDTH-1:0] r_b;     // multiplier, consumed from the LSB end
  logic [PW-1:0]         r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;

  alu_op_decoder u_dec (
    .i_alu_op        (ALUOp),
    .i_func          (ALUFunction),
    .o_alu_operation (w_alu_op),
    .o_multicycle    (w_multicycle)
  );

  assign alu_operation_o = w_alu_op;
  assign multicycle_o    = w_multicycle;
  assign w_is_squ        = (w_alu_op == OP_SQU);
  // Flush beats start in IDLE; single-cycle ops never enter the sequencer
  assign w_accept        = (r_state == S_IDLE) && start_i && w_multicycle && !flush_i;

`ifdef ALU_SIGNED_MUL_EN
  logic w_neg;
  logic r_neg;

  // Magnitude of the most negative value still fits DATA_WIDTH unsigned bits
  assign w_mag_a  = a_i[DATA_WIDTH-1] ? -a_i : a_i;
  assign w_mag_b  = b_i[DATA_WIDTH-1] ? -b_i : b_i;
  assign w_neg    = w_is_squ ? 1'b0 : (a_i[DATA_WIDTH-1] ^ b_i[DATA_WIDTH-1]);
  assign w_result = r_neg ? -w_acc_nxt : w_acc_nxt;

  // Result sign captured alongside the operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_neg <= 1'b0;
    else if (w_accept) r_neg <= w_neg;
  end
`else
  assign w_mag_a  = a_i;
  assign w_mag_b  = b_i;
  assign w_result = w_acc_nxt;
`endif

  // Partial product for the STEP_BITS low multiplier bits
  always_comb begin
    w_partial = '0;
    for (int k = 0; k < STEP_BITS; k++) begin
      if (r_b[k]) w_partial = w_partial + (r_a << k);
    end
  end

  assign w_acc_nxt = r_acc + w_partial;

  // Sequencer FSM with operand/accumulator datapath and product registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= {{DATA_WIDTH{1'b0}}, w_mag_a};
            r_b     <= w_is_squ ? w_mag_a : w_mag_b;
            r_acc   <= '0;
            r_cnt   <= CNT_W'(N);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            r_a   <= r_a << STEP_BITS;
            r_b   <= r_b >> STEP_BITS;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              {r_hi, r_lo} <= w_result;
              r_state      <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = (r_state == S_RUN);
  assign stall_o      = (r_state == S_RUN);
  assign done_o       = (r_state == S_DONE);
  assign product_hi_o = r_hi;
  assign product_lo_o = r_lo;

endmodule

// File: tb/tb_alu_multicycle_ctrl.sv
// Self-checking bench for alu_multicycle_ctrl: 32-bit/1-step and 8-bit/2-step
// instances, directed cases plus random MULT/SQU against an arithmetic model.
module tb_alu_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  // 32-bit instance
  logic [2:0]  ALUOp;
  logic [5:0]  ALUFunction;
  logic        start_i, flush_i;
  logic [31:0] a_i, b_i;
  logic [3:0]  alu_operation_o;
  logic        multicycle_o, busy_o, stall_o, done_o;
  logic [31:0] product_hi_o, product_lo_o;
  // 8-bit, 2 bits/cycle instance
  logic [2:0]  op8;
  logic [5:0]  fn8;
  logic        start8, flush8;
  logic [7:0]  a8, b8;
  logic [3:0]  aluop8_o;
  logic        mc8, busy8, stall8, done8;
  logic [7:0]  hi8, lo8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_multicycle_ctrl #(.DATA_WIDTH(32), .STEP_BITS(1)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .ALUFunction(ALUFunction),
    .start_i(start_i), .flush_i(flush_i), .a_i(a_i), .b_i(b_i),
    .alu_operation_o(alu_operation_o), .multicycle_o(multicycle_o),
    .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
    .product_hi_o(product_hi_o), .product_lo_o(product_lo_o)
  );

  alu_multicycle_ctrl #(.DATA_WIDTH(8), .STEP_BITS(2)) dut8 (
    .clk(clk), .reset(reset), .ALUOp(op8), .ALUFunction(fn8),
    .start_i(start8), .flush_i(flush8), .a_i(a8), .b_i(b8),
    .alu_operation_o(aluop8_o), .multicycle_o(mc8),
    .busy_o(busy8), .stall_o(stall8), .done_o(done8),
    .product_hi_o(hi8), .product_lo_o(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference products: plain full-width arithmetic
  function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_SIGNED_MUL_EN
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    return {32'd0, a} * {32'd0, b};
`endif
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b);
`ifdef ALU_SIGNED_MUL_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 16'(sa * sb);
`else
    return {8'd0, a} * {8'd0, b};
`endif
  endfunction

  // One full 32-bit multiply: latency, handshake and product checks
  task automatic run32(input logic [2:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input string tag);
    int nb;
    @(negedge clk);
    ALUOp = op; ALUFunction = fn; a_i = a; b_i = b; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; a_i = $urandom; b_i = $urandom;  // operands must be latched
    nb = 0;
    while (busy_o && nb < 100) begin
      if (!stall_o) nb = 1000;
      nb++;
      @(negedge clk);
    end
    chk({tag, " busy/stall cycles"}, 64'(nb), 64'd32);
    chk({tag, " done"}, 64'(done_o), 64'd1);
    chk({tag, " stall in done"}, 64'(stall_o), 64'd0);
    chk({tag, " product"}, {product_hi_o, product_lo_o}, exp);
    @(negedge clk);
    chk({tag, " done single pulse"}, 64'(done_o), 64'd0);
    chk({tag, " product held"}, {product_hi_o, product_lo_o}, exp);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                      input string tag);
    int nb;
    @(negedge clk);
    op8 = 3'b111; fn8 = 6'b100101; a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    nb = 0;
    while (busy8 && nb < 100) begin nb++; @(negedge clk); end
    chk({tag, " busy cycles"}, 64'(nb), 64'd4);
    chk({tag, " done"}, 64'(done8), 64'd1);
    chk({tag, " product"}, 64'({hi8, lo8}), 64'(exp));
  endtask

  initial begin : main
    logic [2:0]  dop [12];
    logic [5:0]  dfn [12];
    logic [3:0]  dexp[12];
    logic [31:0] ra, rb;
    logic [7:0]  r8a, r8b;
    logic        sq, seen;

    reset = 1'b1; start_i = 0; flush_i = 0; ALUOp = 3'b111; ALUFunction = 6'b100101;
    a_i = '0; b_i = '0; start8 = 0; flush8 = 0; op8 = '0; fn8 = '0; a8 = '0; b8 = '0;
    #1;
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset stall", 64'(stall_o), 64'd0);
    chk("reset done", 64'(done_o), 64'd0);
    chk("reset product", {product_hi_o, product_lo_o}, 64'd0);
    chk("decode MULT in reset", 64'(alu_operation_o), 64'h6);
    chk("multicycle MULT", 64'(multicycle_o), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Decode table; don't-care function fields randomized
    dop = '{3'b111, 3'b111, 3'b111, 3'b100, 3'b101, 3'b001, 3'b010, 3'b111, 3'b011, 3'b000, 3'b111, 3'b110};
    dfn = '{6'b100100, 6'b100111, 6'b100000, 6'($urandom), 6'($urandom), 6'($urandom),
            6'($urandom), 6'b100101, 6'($urandom), 6'($urandom), 6'b000000, 6'($urandom)};
    dexp = '{4'h0, 4'h2, 4'h3, 4'h3, 4'h1, 4'h4, 4'h5, 4'h6, 4'h9, 4'h9, 4'h9, 4'h9};
    for (int i = 0; i < 12; i++) begin
      ALUOp = dop[i]; ALUFunction = dfn[i];
      #1;
      chk($sformatf("decode %b_%b", dop[i], dfn[i]), 64'(alu_operation_o), 64'(dexp[i]));
      chk($sformatf("multicycle %b_%b", dop[i], dfn[i]), 64'(multicycle_o),
          64'((dexp[i] == 4'h5) || (dexp[i] == 4'h6)));
    end

    // Directed multiplies
    run32(3'b111, 6'b100101, 32'd7, 32'd6, 64'd42, "MULT 7*6");
`ifdef ALU_SIGNED_MUL_EN
    run32(3'b111, 6'b100101, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE, "MULT -1*2");
    run32(3'b111, 6'b100101, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, "MULT -3*5");
    run32(3'b010, 6'b000000, 32'h80000000, 32'd7, 64'h40000000_00000000, "SQU min neg");
    run32(3'b111, 6'b100101, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "MULT min*min");
`else
    run32(3'b111, 6'b100101, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, "MULT max*2");
    run32(3'b111, 6'b100101, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "MULT max*max");
`endif
    run32(3'b010, 6'b101010, 32'h00010000, 32'h0000DEAD, 64'h00000001_00000000, "SQU b ignored");
    run32(3'b111, 6'b100101, 32'd0, 32'hFFFFFFFF, 64'd0, "MULT zero");

    // Random MULT/SQU against the model
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; sq = 1'($urandom_range(0, 1));
      run32(sq ? 3'b010 : 3'b111, sq ? 6'($urandom) : 6'b100101, ra, rb,
            model32(ra, sq ? ra : rb), $sformatf("rand%0d %s", i, sq ? "SQU" : "MULT"));
    end

    // Re-establish 42 in the product registers
    run32(3'b111, 6'b100101, 32'd7, 32'd6, 64'd42, "MULT 7*6 again");

    // Single-cycle op with start: never engages the sequencer
    @(negedge clk);
    ALUOp = 3'b100; ALUFunction = 6'($urandom); start_i = 1'b1;
    #1;
    chk("ADDI decode", 64'(alu_operation_o), 64'h3);
    chk("ADDI multicycle", 64'(multicycle_o), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 3) start_i = 1'b0;
      if (busy_o || stall_o || done_o) seen = 1'b1;
    end
    chk("ADDI no busy/stall/done", 64'(seen), 64'd0);

    // Flush at RUN cycle 10 with a simultaneous start
    @(negedge clk);
    ALUOp = 3'b111; ALUFunction = 6'b100101; a_i = $urandom; b_i = $urandom; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy before flush", 64'(busy_o), 64'd1);
    flush_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    chk("idle after flush", 64'(busy_o), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy_o || done_o) seen = 1'b1;
    end
    chk("no done/busy after flush", 64'(seen), 64'd0);
    chk("product kept after flush", {product_hi_o, product_lo_o}, 64'd42);

    // Flush and start together in IDLE: nothing accepted
    @(negedge clk);
    flush_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    chk("flush beats start", 64'(busy_o), 64'd0);
    repeat (3) @(negedge clk);
    chk("flush beats start later", 64'(busy_o | done_o), 64'd0);

    // Async reset mid-RUN
    @(negedge clk);
    a_i = 32'd5; b_i = 32'd9; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", 64'(busy_o), 64'd0);
    chk("async reset stall", 64'(stall_o), 64'd0);
    chk("async reset done", 64'(done_o), 64'd0);
    chk("async reset product", {product_hi_o, product_lo_o}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run32(3'b111, 6'b100101, 32'd3, 32'd3, 64'd9, "MULT 3*3 after reset");

    // 8-bit, 2 bits per cycle
    run8(8'd13, 8'd11, 16'h008F, "W8 13*11");
    for (int i = 0; i < 4; i++) begin
      r8a = 8'($urandom); r8b = 8'($urandom);
      run8(r8a, r8b, model8(r8a, r8b), $sformatf("W8 rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
